// File: rtl/fir_coef_ram_ctrl_if.sv
// Bundle between the FIR coefficient sequencer and its neighbours: the update
// handshake, the coefficient stream to the MAC, and the coefficient SRAM pins.
interface fir_coef_ram_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  iUpdValid;
  logic                  oUpdReady;
  logic [ADDR_WIDTH-1:0] iUpdAddr;
  logic [DATA_WIDTH-1:0] iUpdData;
  logic                  oUpdErr;
  logic                  iMacStart;
  logic                  oStartOvr;
  logic                  oCoefValid;
  logic [ADDR_WIDTH-1:0] oCoefIdx;
  logic [DATA_WIDTH-1:0] oCoef;
  logic                  oSweepDone;
  logic                  oBusy;
  logic                  oCsnRam;
  logic                  oWrnRam;
  logic [ADDR_WIDTH-1:0] oAddrRam;
  logic [DATA_WIDTH-1:0] oWrDtRam;
  logic [DATA_WIDTH-1:0] iRdDtRam;

  modport slave (
    input  iUpdValid, iUpdAddr, iUpdData, iMacStart, iRdDtRam,
    output oUpdReady, oUpdErr, oStartOvr, oCoefValid, oCoefIdx, oCoef,
           oSweepDone, oBusy, oCsnRam, oWrnRam, oAddrRam, oWrDtRam
  );

  modport master (
    output iUpdValid, iUpdAddr, iUpdData, iMacStart, iRdDtRam,
    input  oUpdReady, oUpdErr, oStartOvr, oCoefValid, oCoefIdx, oCoef,
           oSweepDone, oBusy, oCsnRam, oWrnRam, oAddrRam, oWrDtRam
  );
endinterface

// File: rtl/fir_coef_ram_ctrl.sv
// Coefficient SRAM sequencer: writes coefficient updates and sweeps taps 1..ADDR_DEPTH to the MAC.
// Optional macro COEF_SYM_EN: store only half the taps and mirror the upper half on readout.
module fir_coef_ram_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_DEPTH = 33,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  iClk_12M,
  input  logic                  iRst,
  fir_coef_ram_ctrl_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, WR, RD, FLUSH} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ADDR_DEPTH);
`ifdef COEF_SYM_EN
  localparam logic [ADDR_WIDTH-1:0] LIMIT  = ADDR_WIDTH'((ADDR_DEPTH + 1) / 2);
  localparam logic [ADDR_WIDTH-1:0] MIRROR = ADDR_WIDTH'(ADDR_DEPTH + 1);
`else
  localparam logic [ADDR_WIDTH-1:0] LIMIT  = LAST;
`endif

  // Tap index to physical SRAM address.
  function automatic logic [ADDR_WIDTH-1:0] map_tap(input logic [ADDR_WIDTH-1:0] k);
`ifdef COEF_SYM_EN
    return (k <= LIMIT) ? k : MIRROR - k;
`else
    return k;
`endif
  endfunction

  state_t                state_q;
  logic                  pend_q, live_q;
  logic [ADDR_WIDTH-1:0] tap_q, tap_d;
  logic                  csn_q, wrn_q, err_q, ovr_q;
  logic [ADDR_WIDTH-1:0] addr_q, idx_q;
  logic [DATA_WIDTH-1:0] wrdt_q;
  logic                  vld_q, done_q;
  logic                  rdy, upd_acc, upd_legal;

  // live_q holds ready low until the first edge after reset release.
  assign rdy       = live_q & (state_q == IDLE) & ~pend_q;
  assign upd_acc   = bus.iUpdValid & rdy;
  assign upd_legal = (bus.iUpdAddr != '0) && (bus.iUpdAddr <= LIMIT);
  assign tap_d     = tap_q + 1'b1;

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      live_q  <= 1'b0;
      tap_q   <= '0;
      csn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      addr_q  <= '0;
      wrdt_q  <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      csn_q  <= 1'b1;
      wrn_q  <= 1'b1;
      err_q  <= 1'b0;
      ovr_q  <= 1'b0;
      // Read return lags the presented address by one cycle.
      vld_q  <= (state_q == RD);
      idx_q  <= (state_q == RD) ? tap_q : '0;
      done_q <= (state_q == RD) && (tap_q == LAST);
      case (state_q)
        IDLE: begin
          if (upd_acc) begin
            state_q <= WR;
            if (upd_legal) begin
              csn_q  <= 1'b0;
              wrn_q  <= 1'b0;
              addr_q <= bus.iUpdAddr;
              wrdt_q <= bus.iUpdData;
            end else begin
              err_q  <= 1'b1;
            end
            if (bus.iMacStart) pend_q <= 1'b1;
          end else if (bus.iMacStart || pend_q) begin
            state_q <= RD;
            pend_q  <= 1'b0;
            tap_q   <= ADDR_WIDTH'(1);
            csn_q   <= 1'b0;
            addr_q  <= map_tap(ADDR_WIDTH'(1));
            if (bus.iMacStart && pend_q) ovr_q <= 1'b1;
          end
        end
        WR: begin
          state_q <= IDLE;
          if (bus.iMacStart) begin
            if (pend_q) ovr_q  <= 1'b1;
            else        pend_q <= 1'b1;
          end
        end
        RD: begin
          if (bus.iMacStart) ovr_q <= 1'b1;
          if (tap_q == LAST) begin
            state_q <= FLUSH;
          end else begin
            tap_q  <= tap_d;
            csn_q  <= 1'b0;
            addr_q <= map_tap(tap_d);
          end
        end
        FLUSH: begin
          if (bus.iMacStart) ovr_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oUpdReady  = rdy;
  assign bus.oUpdErr    = err_q;
  assign bus.oStartOvr  = ovr_q;
  assign bus.oCoefValid = vld_q;
  assign bus.oCoefIdx   = idx_q;
  assign bus.oCoef      = bus.iRdDtRam;
  assign bus.oSweepDone = done_q;
  assign bus.oBusy      = (state_q != IDLE) || pend_q;
  assign bus.oCsnRam    = csn_q;
  assign bus.oWrnRam    = wrn_q;
  assign bus.oAddrRam   = addr_q;
  assign bus.oWrDtRam   = wrdt_q;
endmodule
